// File: rtl/data_stream_sink_fifo_if.sv
// Stream bundle between the delayed-data producer, the sink FIFO and its consumer.
// The slave modport is the FIFO's view of the bundle; the master modport is the environment's view.
interface data_stream_sink_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             i_valid;
    logic [WIDTH-1:0] i_data;
    logic             i_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic [CW-1:0]    o_count;
    logic             o_full;
    logic             o_overflow;
    logic [CNT_W-1:0] o_drop_count;

    modport master (
        output i_valid, i_data, i_ready,
        input  o_valid, o_data, o_count, o_full, o_overflow, o_drop_count
    );

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_valid, o_data, o_count, o_full, o_overflow, o_drop_count
    );
endinterface

// File: rtl/data_stream_sink_fifo.sv
// FWFT sink FIFO: a word pushed at edge N is visible on o_valid/o_data in cycle N+1.
// The upstream cannot be stalled: words arriving while full (and not popping) are dropped and counted.
module data_stream_sink_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    data_stream_sink_fifo_if.slave s
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic [CNT_W-1:0] drop_q,   drop_d;

    logic full, pop, push, drop;

    assign full = (count_q == DEPTH_C);
    assign pop  = (count_q != '0) && s.i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = s.i_valid && (!full || pop);
    assign drop = s.i_valid && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            drop_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            if (push && !i_clear) mem_q[wr_ptr_q] <= s.i_data;
        end
    end

    assign s.o_valid      = (count_q != '0);
    assign s.o_full       = full;
    assign s.o_data       = mem_q[rd_ptr_q];
    assign s.o_count      = count_q;
    assign s.o_overflow   = ovf_q;
    assign s.o_drop_count = drop_q;

    a_count_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        count_q <= DEPTH_C);
    a_no_empty_pop: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        pop |-> (count_q != '0));
    a_drop_monotonic: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !$past(i_clear) |-> (drop_q >= $past(drop_q)));
endmodule

// File: tb/tb_data_stream_sink_fifo.sv
module tb_data_stream_sink_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    data_stream_sink_fifo_if #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) bus ();

    data_stream_sink_fifo #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clear (clear),
        .s       (bus.slave)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        c;
        logic        e_v;
        logic [31:0] e_d;
        logic [2:0]  e_cnt;
        logic        e_full;
        logic        e_ovf;
        logic [1:0]  e_drop;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic r, input logic c,
                                input logic e_v, input logic [31:0] e_d, input logic [2:0] e_cnt,
                                input logic e_full, input logic e_ovf, input logic [1:0] e_drop);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.c = c;
        t.e_v = e_v; t.e_d = e_d; t.e_cnt = e_cnt;
        t.e_full = e_full; t.e_ovf = e_ovf; t.e_drop = e_drop;
        return t;
    endfunction

    // Drive one cycle: scoreboard checks popped data before the edge, models the push, then advances.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic c);
        bit was_full, popped;
        bus.i_valid = v; bus.i_data = d; bus.i_ready = r; clear = c;
        #1;
        was_full = (sb.size() == 4);
        popped   = bus.o_valid && r;
        if (popped) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("pop_data", bus.o_data, sb.pop_front());
        end
        if (c) sb.delete();
        else if (v && (!was_full || popped)) sb.push_back(d);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0; bus.i_ready = 1'b0; clear = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic e_v, input logic [31:0] e_d,
                             input logic [2:0] e_cnt, input logic e_full, input logic e_ovf,
                             input logic [1:0] e_drop);
        chk({tag, ".valid"}, 32'(bus.o_valid), 32'(e_v));
        chk({tag, ".count"}, 32'(bus.o_count), 32'(e_cnt));
        chk({tag, ".full"},  32'(bus.o_full), 32'(e_full));
        chk({tag, ".ovf"},   32'(bus.o_overflow), 32'(e_ovf));
        chk({tag, ".drop"},  32'(bus.o_drop_count), 32'(e_drop));
        if (e_v) chk({tag, ".data"}, bus.o_data, e_d);
    endtask

    initial begin
        bus.i_valid = 1'b0; bus.i_data = '0; bus.i_ready = 1'b0;

        // Fill 3 with ready low, then drain.
        vecs.push_back(mk(1, 32'h11, 0, 0, 1, 32'h11, 1, 0, 0, 0));
        vecs.push_back(mk(1, 32'h22, 0, 0, 1, 32'h11, 2, 0, 0, 0));
        vecs.push_back(mk(1, 32'h33, 0, 0, 1, 32'h11, 3, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,  1, 0, 1, 32'h22, 2, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,  1, 0, 1, 32'h33, 1, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 32'h0,  0, 0, 0, 0));
        // Overfill: A4, A5 dropped.
        vecs.push_back(mk(1, 32'hA0, 0, 0, 1, 32'hA0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 32'hA1, 0, 0, 1, 32'hA0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 32'hA2, 0, 0, 1, 32'hA0, 3, 0, 0, 0));
        vecs.push_back(mk(1, 32'hA3, 0, 0, 1, 32'hA0, 4, 1, 0, 0));
        vecs.push_back(mk(1, 32'hA4, 0, 0, 1, 32'hA0, 4, 1, 1, 1));
        vecs.push_back(mk(1, 32'hA5, 0, 0, 1, 32'hA0, 4, 1, 1, 2));
        // Push while full with a simultaneous pop: accepted, not dropped.
        vecs.push_back(mk(1, 32'hB0, 1, 0, 1, 32'hA1, 4, 1, 1, 2));
        vecs.push_back(mk(0, 32'h0,  1, 0, 1, 32'hA2, 3, 0, 1, 2));
        vecs.push_back(mk(0, 32'h0,  1, 0, 1, 32'hA3, 2, 0, 1, 2));
        vecs.push_back(mk(0, 32'h0,  1, 0, 1, 32'hB0, 1, 0, 1, 2));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 32'h0,  0, 0, 1, 2));
        // Clear, refill, 5 drops saturating at 3.
        vecs.push_back(mk(0, 32'h0,  0, 1, 0, 32'h0,  0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h50, 0, 0, 1, 32'h50, 1, 0, 0, 0));
        vecs.push_back(mk(1, 32'h51, 0, 0, 1, 32'h50, 2, 0, 0, 0));
        vecs.push_back(mk(1, 32'h52, 0, 0, 1, 32'h50, 3, 0, 0, 0));
        vecs.push_back(mk(1, 32'h53, 0, 0, 1, 32'h50, 4, 1, 0, 0));
        vecs.push_back(mk(1, 32'h54, 0, 0, 1, 32'h50, 4, 1, 1, 1));
        vecs.push_back(mk(1, 32'h55, 0, 0, 1, 32'h50, 4, 1, 1, 2));
        vecs.push_back(mk(1, 32'h56, 0, 0, 1, 32'h50, 4, 1, 1, 3));
        vecs.push_back(mk(1, 32'h57, 0, 0, 1, 32'h50, 4, 1, 1, 3));
        vecs.push_back(mk(1, 32'h58, 0, 0, 1, 32'h50, 4, 1, 1, 3));
        // Clear together with a valid word and a ready: word lost, nothing counted.
        vecs.push_back(mk(1, 32'h59, 1, 1, 0, 32'h0,  0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h5A, 0, 0, 1, 32'h5A, 1, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 32'h0,  0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_state("reset", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 2'd0);
        chk("reset.data", bus.o_data, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c);
            chk_state($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_d, vecs[i].e_cnt,
                      vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_drop);
        end
        chk("sb_empty_after_vecs", 32'(sb.size()), 32'd0);

        // Async reset mid-cycle while full with a recorded drop.
        cycle(1, 32'h61, 0, 0);
        cycle(1, 32'h62, 0, 0);
        cycle(1, 32'h63, 0, 0);
        cycle(1, 32'h64, 0, 0);
        cycle(1, 32'h65, 0, 0);
        chk_state("prerst", 1'b1, 32'h61, 3'd4, 1'b1, 1'b1, 2'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_state("async_rst", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 2'd0);
        chk("async_rst.data", bus.o_data, 32'h0);
        sb.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1, 32'hC0, 0, 0);
        chk_state("post_rst", 1'b1, 32'hC0, 3'd1, 1'b0, 1'b0, 2'd0);
        cycle(0, 32'h0, 1, 0);
        chk_state("post_rst_pop", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
